arbiter_collector: RTL and testbench

- Gathers the four per-unit result buses (channel ids 1..4, matching the 3-bit control encoding used on the distribution side) back onto a single output bus.
- Each channel has a one-entry holding register with a valid/ready handshake.
- Pending entries are drained round-robin through a single valid/ready output port, tagged with their channel id.
- A frame-done pulse marks the point where every channel has been delivered once.

---
 rtl/arbiter_collector.sv | 95 +++++++++
 tb/tb_arbiter_collector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_collector.sv
// arbiter_collector: gathers four channel result buses onto one round-robin output bus
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   in_1..in_4, in_valid     per-channel payloads and valid strobes (bit k-1 = channel k)
//   in_ready                 per-channel holding register empty
//   out_data, out_id         registered payload and its channel id (1..4, 0 when idle)
//   out_valid, out_ready     output handshake
//   frame_done               one-cycle pulse once every channel has been delivered in a frame
module arbiter_collector #(
    parameter int data_width = 4352
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [data_width-1:0] in_1,
    input  logic [data_width-1:0] in_2,
    input  logic [data_width-1:0] in_3,
    input  logic [data_width-1:0] in_4,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    output logic [data_width-1:0] out_data,
    output logic [2:0]            out_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t                state_q, state_d;
    logic [3:0]            pending_q, pending_d, sent_q, sent_d, cap, sent_next;
    logic [data_width-1:0] hold_q [4];
    logic [data_width-1:0] hold_d [4];
    logic [data_width-1:0] in_bus [4];
    logic [data_width-1:0] data_q, data_d;
    logic [1:0]            ptr_q, ptr_d, sel;
    logic [2:0]            id_q, id_d;
    logic                  found, load, handshake, frame_done_q, frame_done_d;
    assign in_bus[0] = in_1;
    assign in_bus[1] = in_2;
    assign in_bus[2] = in_3;
    assign in_bus[3] = in_4;
    // ptr_q holds the index (channel-1) where the search starts; scanning the
    // offsets downward lets the nearest pending channel win.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[ptr_q + 2'(i)]) begin
                found = 1'b1;
                sel   = ptr_q + 2'(i);
            end
        end
    end
    always_comb begin
        handshake    = (state_q == SEND) && out_ready;
        load         = found && ((state_q == IDLE) || out_ready);
        state_d      = load ? SEND : (handshake ? IDLE : state_q);
        cap          = in_valid & ~pending_q;
        pending_d    = (pending_q & ~(load ? 4'b0001 << sel : 4'b0000)) | cap;
        for (int k = 0; k < 4; k++) hold_d[k] = cap[k] ? in_bus[k] : hold_q[k];
        data_d       = load ? hold_q[sel] : data_q;
        id_d         = load ? {1'b0, sel} + 3'd1 : (handshake ? 3'd0 : id_q);
        ptr_d        = load ? sel + 2'd1 : ptr_q;
        // id 4 maps to bit 3 through the 2-bit wrap of (id-1)
        sent_next    = sent_q | (4'b0001 << (id_q[1:0] - 2'd1));
        frame_done_d = handshake && (&sent_next);
        sent_d       = handshake ? ((&sent_next) ? 4'b0000 : sent_next) : sent_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            sent_q       <= '0;
            data_q       <= '0;
            ptr_q        <= '0;
            id_q         <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 4; k++) hold_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            sent_q       <= sent_d;
            data_q       <= data_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 4; k++) hold_q[k] <= hold_d[k];
        end
    end
    always_comb begin
        out_valid  = state_q == SEND;
        out_id     = id_q;
        out_data   = data_q;
        in_ready   = ~pending_q;
        frame_done = frame_done_q;
    end
endmodule

// File: tb/tb_arbiter_collector.sv
// tb_arbiter_collector: scoreboard bench for arbiter_collector with directed and random traffic
module tb_arbiter_collector;
    localparam int DW = 4352;
    typedef logic [DW-1:0] word_t;

    logic       clock, reset, out_valid, out_ready, frame_done;
    logic [3:0] in_valid, in_ready;
    logic [2:0] out_id;
    word_t      out_data;
    word_t      in_bus [4];

    arbiter_collector #(.data_width(DW)) dut (
        .clock(clock), .reset(reset),
        .in_1(in_bus[0]), .in_2(in_bus[1]), .in_3(in_bus[2]), .in_4(in_bus[3]),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_id(out_id), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int    n_cmp = 0;
    int    n_err = 0;
    word_t chan_q [4][$];
    int    ord_q [$];
    int    wait_cnt [4];
    logic [3:0] mask;
    logic  fd_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got low64 %0h expected low64 %0h at %0t", name, act[63:0], exp[63:0], $time);
        end
    endtask

    function automatic word_t rnd_word();
        word_t w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: per-channel payload queues, expected order, frame and fairness model
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                chan_q[k].delete();
                wait_cnt[k] = 0;
            end
            ord_q.delete();
            mask   = 4'b0000;
            fd_exp = 1'b0;
        end else begin
            chk("frame_done", frame_done, fd_exp);
            fd_exp = 1'b0;
            if (!out_valid) chk("idle_id", out_id, 0);
            if (out_valid && out_ready) begin
                if (out_id < 1 || out_id > 4) begin
                    chk("out_id_range", out_id, 1);
                end else begin
                    int c;
                    c = int'(out_id) - 1;
                    if (chan_q[c].size() == 0) begin
                        chk("unexpected_xfer_ch", out_id, 0);
                    end else begin
                        chk_data("payload", out_data, chan_q[c].pop_front());
                    end
                    if (ord_q.size() > 0) chk("order", out_id, ord_q.pop_front());
                    for (int k = 0; k < 4; k++) begin
                        if (k != c && chan_q[k].size() > 0) begin
                            wait_cnt[k]++;
                            chk("fair_wait_le3", wait_cnt[k] <= 3, 1);
                        end
                    end
                    wait_cnt[c] = 0;
                    mask[c] = 1'b1;
                    if (mask == 4'b1111) begin
                        fd_exp = 1'b1;
                        mask   = 4'b0000;
                    end
                end
            end
            for (int k = 0; k < 4; k++)
                if (in_valid[k] && in_ready[k]) chan_q[k].push_back(in_bus[k]);
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) in_bus[k] = '0;
        repeat (3) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 4'b1111);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ready", in_ready, 4'b1111);
            chk("idle_valid", out_valid, 0);
            chk("idle_fd", frame_done, 0);
        end

        // single capture on channel 3
        out_ready = 1'b1;
        in_bus[2] = word_t'(32'hA5);
        in_valid  = 4'b0100;
        ord_q.push_back(3);
        step();
        in_valid = 4'b0000;
        chk("t2_ready_busy", in_ready, 4'b1011);
        chk("t2_not_yet", out_valid, 0);
        step();
        chk("t2_valid", out_valid, 1);
        chk("t2_id", out_id, 3);
        chk_data("t2_data", out_data, word_t'(32'hA5));
        chk("t2_ready_back", in_ready, 4'b1111);
        step();
        chk("t2_done_valid", out_valid, 0);
        chk("t2_done_id", out_id, 0);

        // fresh frame, pointer back at channel 1
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();

        // all four at once: back-to-back ids 1..4, then frame_done
        for (int k = 0; k < 4; k++) in_bus[k] = word_t'(k + 1);
        in_valid = 4'b1111;
        for (int k = 1; k <= 4; k++) ord_q.push_back(k);
        step();
        in_valid = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t3_valid", out_valid, 1);
            chk("t3_id", out_id, i);
            chk_data("t3_data", out_data, word_t'(i));
            chk("t3_fd_low", frame_done, 0);
        end
        step();
        chk("t3_idle", out_valid, 0);
        chk("t3_fd_pulse", frame_done, 1);
        step();
        chk("t3_fd_cleared", frame_done, 0);

        // backpressure on channel 2
        out_ready = 1'b0;
        in_bus[1] = word_t'(32'h55);
        in_valid  = 4'b0010;
        ord_q.push_back(2);
        step();
        in_valid = 4'b0000;
        step();
        repeat (5) begin
            chk("t4_valid", out_valid, 1);
            chk("t4_id", out_id, 2);
            chk_data("t4_data", out_data, word_t'(32'h55));
            chk("t4_ready", in_ready, 4'b1111);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t4_single", out_valid, 0);
        chk("t4_id_idle", out_id, 0);
        chk_data("t4_data_kept", out_data, word_t'(32'h55));

        // fairness: deliver channel 1 so the pointer sits at 2, then 1 and 4 contend
        in_bus[0] = rnd_word();
        in_valid  = 4'b0001;
        ord_q.push_back(1);
        step();
        in_valid = 4'b0000;
        step();
        step();
        chk("t5_solo_done", out_valid, 0);
        ord_q.push_back(4);
        ord_q.push_back(1);
        ord_q.push_back(4);
        ord_q.push_back(1);
        ord_q.push_back(4);
        ord_q.push_back(1);
        in_valid = 4'b1001;
        repeat (14) begin
            in_bus[0] = rnd_word();
            in_bus[3] = rnd_word();
            step();
        end
        in_valid = 4'b0000;
        repeat (6) step();
        chk("t5_order_drained", ord_q.size(), 0);
        chk("t5_idle", out_valid, 0);

        // reset while sending with three channels still pending
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) in_bus[k] = rnd_word();
        in_valid = 4'b1111;
        step();
        in_valid = 4'b0000;
        step();
        chk("t6_sending", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_id", out_id, 0);
        chk_data("t6_rst_data", out_data, '0);
        chk("t6_rst_fd", frame_done, 0);
        chk("t6_rst_ready", in_ready, 4'b1111);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_no_stale", out_valid, 0);
            chk("t6_no_fd", frame_done, 0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) in_bus[k] = rnd_word();
            in_valid  = 4'($urandom());
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        repeat (10) step();
        chk("drain_left", chan_q[0].size() + chan_q[1].size() + chan_q[2].size() + chan_q[3].size(), 0);
        chk("drain_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
